// File: rtl/contador_regressivo.sv
// contador_regressivo: loadable down-counter with pause/resume, restart,
// a one-shot half-way pulse and an expiry pulse. All outputs registered.
module contador_regressivo #(
    parameter int M = 1000,
    parameter int N = 10
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         inicia,
    input  logic [N-1:0] valor,
    input  logic         conta,
    input  logic         pausa,
    output logic [N-1:0] Q,
    output logic         fim,
    output logic         meio,
    output logic         ocupado
);

    localparam logic [N-1:0] MAX_V = N'(M - 1);
    localparam logic [N-1:0] UM    = N'(1);
    localparam logic [N-1:0] DOIS  = N'(2);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2
    } estado_t;

    estado_t      estado_q, estado_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] carga_q, carga_d;
    logic         fim_q, fim_d;
    logic         meio_q, meio_d;
    logic         meio_feito_q, meio_feito_d;
    logic         ocupado_q, ocupado_d;
    logic [N-1:0] sat;
    logic [N-1:0] q_menos;

    // Start value clamped to the largest count this instance supports.
    assign sat     = (valor > MAX_V) ? MAX_V : valor;
    assign q_menos = q_q - UM;

    // Next-state: inicia overrides everything except reset; pausa beats conta.
    always_comb begin
        estado_d     = estado_q;
        q_d          = q_q;
        carga_d      = carga_q;
        meio_feito_d = meio_feito_q;
        fim_d        = 1'b0;
        meio_d       = 1'b0;
        if (inicia) begin
            carga_d      = sat;
            q_d          = sat;
            meio_feito_d = 1'b0;
            if (sat == '0) begin
                // Zero-length run expires immediately without ever going busy.
                estado_d = OCIOSO;
                fim_d    = 1'b1;
            end else begin
                estado_d = CONTANDO;
            end
        end else begin
            case (estado_q)
                CONTANDO: begin
                    if (pausa) begin
                        estado_d = PAUSADO;
                    end else if (conta) begin
                        if (q_q > UM) begin
                            q_d = q_menos;
                            // Half-way mark fires once per run; carga<2 has no distinct midpoint.
                            if (!meio_feito_q && (carga_q >= DOIS) && (q_menos == (carga_q >> 1))) begin
                                meio_d       = 1'b1;
                                meio_feito_d = 1'b1;
                            end
                        end else if (q_q == UM) begin
                            q_d      = '0;
                            fim_d    = 1'b1;
                            estado_d = OCIOSO;
                        end
                    end
                end
                PAUSADO: begin
                    // Resume edge consumes the cycle; conta here is dropped.
                    if (!pausa) estado_d = CONTANDO;
                end
                default: ;
            endcase
        end
        ocupado_d = (estado_d != OCIOSO);
    end

    // State register with synchronous reset taking precedence over all inputs.
    always_ff @(posedge clock) begin
        if (zera_s) begin
            estado_q     <= OCIOSO;
            q_q          <= '0;
            carga_q      <= '0;
            fim_q        <= 1'b0;
            meio_q       <= 1'b0;
            meio_feito_q <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            q_q          <= q_d;
            carga_q      <= carga_d;
            fim_q        <= fim_d;
            meio_q       <= meio_d;
            meio_feito_q <= meio_feito_d;
            ocupado_q    <= ocupado_d;
        end
    end

    assign Q       = q_q;
    assign fim     = fim_q;
    assign meio    = meio_q;
    assign ocupado = ocupado_q;

endmodule

// File: tb/tb_contador_regressivo.sv
// Directed bench for contador_regressivo (M=1000, N=10).
module tb_contador_regressivo;

    logic       clock = 1'b0;
    logic       zera_s, inicia, conta, pausa;
    logic [9:0] valor;
    logic [9:0] Q;
    logic       fim, meio, ocupado;

    int n_chk = 0;
    int n_err = 0;

    contador_regressivo #(.M(1000), .N(10)) dut (
        .clock  (clock),
        .zera_s (zera_s),
        .inicia (inicia),
        .valor  (valor),
        .conta  (conta),
        .pausa  (pausa),
        .Q      (Q),
        .fim    (fim),
        .meio   (meio),
        .ocupado(ocupado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input int q, input int f, input int m, input int o);
        chk({tag, ".Q"}, int'(Q), q);
        chk({tag, ".fim"}, int'(fim), f);
        chk({tag, ".meio"}, int'(meio), m);
        chk({tag, ".ocupado"}, int'(ocupado), o);
    endtask

    initial begin
        // Reset dominates inicia/conta
        zera_s = 1'b1; inicia = 1'b1; conta = 1'b1; pausa = 1'b0; valor = 10'd10;
        tick(); tick();
        chk_all("reset", 0, 0, 0, 0);

        // Basic run: 10 down to 0, meio at 5, fim 10 edges after load
        zera_s = 1'b0; inicia = 1'b1; valor = 10'd10; conta = 1'b1;
        tick();
        chk_all("load10", 10, 0, 0, 1);
        inicia = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            tick();
            chk_all($sformatf("run10_%0d", i), i, (i == 0) ? 1 : 0, (i == 5) ? 1 : 0, (i != 0) ? 1 : 0);
        end
        tick();
        chk_all("run10_after", 0, 0, 0, 0);

        // Saturation and zero load
        inicia = 1'b1; valor = 10'd1023;
        tick();
        chk_all("sat", 999, 0, 0, 1);
        valor = 10'd0;
        tick();
        chk_all("zero", 0, 1, 0, 0);
        inicia = 1'b0;
        tick();
        chk_all("zero_after", 0, 0, 0, 0);

        // Pause holds Q, one dropped cycle on resume
        inicia = 1'b1; valor = 10'd6; conta = 1'b1;
        tick();
        chk_all("p_load", 6, 0, 0, 1);
        inicia = 1'b0;
        tick(); chk_all("p_5", 5, 0, 0, 1);
        tick(); chk_all("p_4", 4, 0, 0, 1);
        pausa = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all($sformatf("p_hold%0d", i), 4, 0, 0, 1);
        end
        pausa = 1'b0;
        tick(); chk_all("p_resume", 4, 0, 0, 1);
        tick(); chk_all("p_3", 3, 0, 1, 1);
        tick(); chk_all("p_2", 2, 0, 0, 1);
        tick(); chk_all("p_1", 1, 0, 0, 1);
        tick(); chk_all("p_0", 0, 1, 0, 0);
        tick(); chk_all("p_after", 0, 0, 0, 0);

        // Restart with sparse ticks: 8 -> 5, then reload 4
        inicia = 1'b1; valor = 10'd8; conta = 1'b0;
        tick();
        chk_all("r_load8", 8, 0, 0, 1);
        inicia = 1'b0;
        for (int k = 7; k >= 5; k--) begin
            conta = 1'b0; tick(); tick();
            chk_all($sformatf("r_idle%0d", k), k + 1, 0, 0, 1);
            conta = 1'b1; tick();
            chk_all($sformatf("r_%0d", k), k, 0, 0, 1);
        end
        inicia = 1'b1; valor = 10'd4; conta = 1'b1;
        tick();
        chk_all("r_load4", 4, 0, 0, 1);
        inicia = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            conta = 1'b0; tick(); tick();
            chk_all($sformatf("r2_idle%0d", k), k + 1, 0, 0, 1);
            conta = 1'b1; tick();
            chk_all($sformatf("r2_%0d", k), k, (k == 0) ? 1 : 0, (k == 2) ? 1 : 0, (k != 0) ? 1 : 0);
        end
        conta = 1'b0;
        tick();
        chk_all("r2_after", 0, 0, 0, 0);

        // Reset colliding with the final decrement suppresses fim
        inicia = 1'b1; valor = 10'd2; conta = 1'b1;
        tick();
        chk_all("c_load", 2, 0, 0, 1);
        inicia = 1'b0;
        tick();
        chk_all("c_1", 1, 0, 1, 1);
        zera_s = 1'b1;
        tick();
        chk_all("c_rst", 0, 0, 0, 0);
        zera_s = 1'b0;
        tick();
        chk_all("c_after", 0, 0, 0, 0);

        // Idle state ignores conta/pausa
        conta = 1'b1; pausa = 1'b1;
        tick();
        chk_all("idle_ign", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
